// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and command record for the ALU command issuer.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_MUL  = 3'd2;
   localparam logic [2:0] OP_DIV  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_OR   = 3'd5;
   localparam logic [2:0] OP_XOR  = 3'd6;
   localparam logic [2:0] OP_NONE = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   typedef struct packed {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } cmd_t;

   localparam int CMD_W = $bits(cmd_t);

   // OP_NONE is the only encoding the ALU core does not implement.
   function automatic logic op_is_valid(input logic [2:0] op);
      return op != OP_NONE;
   endfunction

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Command, response and ALU-side handshake bundle of the ALU command issuer.
interface alu_cmd_issuer_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [2:0]  rsp_op;
   logic [15:0] rsp_result;
   logic        rsp_err;

   logic        alu_start;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [15:0] alu_result;
   logic        alu_done;

   modport master (
      input  cmd_valid, cmd_op, cmd_a, cmd_b,
      output cmd_ready,
      output rsp_valid, rsp_op, rsp_result, rsp_err,
      input  rsp_ready,
      output alu_start, alu_op, alu_a, alu_b,
      input  alu_result, alu_done
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_a, cmd_b,
      input  cmd_ready,
      input  rsp_valid, rsp_op, rsp_result, rsp_err,
      output rsp_ready,
      input  alu_start, alu_op, alu_a, alu_b,
      output alu_result, alu_done
   );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU issuer; wrap-bit pointers, pushes refused while full.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_W
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   // Same index with differing wrap bits means the writer is a full lap ahead.
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
   assign level    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues queued commands one at a time to the ALU core and returns results,
// completing invalid opcodes and hung operations locally with an error flag.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   alu_cmd_issuer_if.master       bus,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int               CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q, state_d;
   cmd_t             cmd_q, cmd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      rsp_result_q, rsp_result_d;
   logic [2:0]       rsp_op_q, rsp_op_d;
   logic             rsp_err_q, rsp_err_d;

   cmd_t             push_cmd;
   cmd_t             head_cmd;
   logic [CMD_W-1:0] fifo_rd_data;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;

   assign push_cmd = {bus.cmd_op, bus.cmd_a, bus.cmd_b};
   assign head_cmd = cmd_t'(fifo_rd_data);

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.cmd_valid),
      .push_data (push_cmd),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cmd_q        <= '0;
         cnt_q        <= '0;
         rsp_result_q <= '0;
         rsp_op_q     <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         cnt_q        <= cnt_d;
         rsp_result_q <= rsp_result_d;
         rsp_op_q     <= rsp_op_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      cnt_d        = cnt_q;
      rsp_result_d = rsp_result_q;
      rsp_op_d     = rsp_op_q;
      rsp_err_d    = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (!op_is_valid(head_cmd.op)) begin
                  rsp_err_d    = 1'b1;
                  rsp_result_d = '0;
                  rsp_op_d     = OP_NONE;
                  state_d      = ST_RESP;
               end else begin
                  cmd_d   = head_cmd;
                  state_d = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end

         // A done sampled on the last allowed cycle still wins over the timeout.
         ST_WAIT: begin
            if (bus.alu_done) begin
               rsp_result_d = bus.alu_result;
               rsp_op_d     = cmd_q.op;
               rsp_err_d    = 1'b0;
               state_d      = ST_RESP;
            end else if (cnt_q == CNT_LAST) begin
               rsp_result_d = '0;
               rsp_op_d     = cmd_q.op;
               rsp_err_d    = 1'b1;
               state_d      = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = bus.alu_done ? ST_DRAIN : ST_IDLE;
            end
         end

         ST_DRAIN: begin
            if (!bus.alu_done) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      fifo_pop      = 1'b0;
      bus.alu_start = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state_q)
         ST_IDLE:  fifo_pop      = ~fifo_empty;
         ST_ISSUE: bus.alu_start = 1'b1;
         ST_RESP:  bus.rsp_valid = 1'b1;
         default:  ;
      endcase
   end

   assign bus.cmd_ready  = ~fifo_full;
   assign bus.alu_op     = cmd_q.op;
   assign bus.alu_a      = cmd_q.a;
   assign bus.alu_b      = cmd_q.b;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_op     = rsp_op_q;
   assign bus.rsp_err    = rsp_err_q;
   assign busy           = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: behavioural ALU, response scoreboard,
// directed scenarios followed by a randomized command stream.
module tb_alu_cmd_issuer;
   import alu_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } tb_cmd_t;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   busy;
   logic [$clog2(DEPTH):0] fifo_level;

   alu_cmd_issuer_if bus();

   alu_cmd_issuer #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   int n_tests  = 0;
   int n_fail   = 0;
   int n_starts = 0;
   int n_rsps   = 0;
   int n_pushes = 0;
   int n_dones  = 0;

   tb_cmd_t expq[$];

   // ALU and response-port controls
   int  alu_lat_fixed = 1;
   bit  alu_stall     = 1'b0;
   bit  rand_hold     = 1'b0;
   bit  rdy_low       = 1'b0;
   bit  rdy_rand      = 1'b0;

   logic [15:0] last_result;
   logic [2:0]  last_op;
   logic        last_err;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference arithmetic of the ALU core on signed 8-bit operands.
   function automatic logic [15:0] alu_math(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int sa;
      int sb;
      int r;
      sa = $signed(a);
      sb = $signed(b);
      case (op)
         OP_ADD:  r = sa + sb;
         OP_SUB:  r = sa - sb;
         OP_MUL:  r = sa * sb;
         OP_DIV:  r = (sb == 0) ? 0 : sa / sb;
         OP_AND:  r = sa & sb;
         OP_OR:   r = sa | sb;
         OP_XOR:  r = sa ^ sb;
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   // Behavioural ALU core: a divide by zero never completes.
   initial begin
      int  alu_rem;
      int  hold_rem;
      bit  alu_pend;
      logic [15:0] res_pend;
      alu_rem  = 0;
      hold_rem = 0;
      alu_pend = 1'b0;
      res_pend = '0;
      bus.alu_done   = 1'b0;
      bus.alu_result = '0;
      forever begin
         @(negedge clk);
         if (bus.alu_done) begin
            if (hold_rem > 0) begin
               hold_rem--;
            end else begin
               bus.alu_done   = 1'b0;
               bus.alu_result = 16'($urandom);
            end
         end
         if (bus.alu_start && !reset) begin
            n_starts++;
            check_output("start_overlap", {30'b0, alu_pend, bus.alu_done}, 0);
            alu_pend = !(bus.alu_op == OP_DIV && bus.alu_b == 8'd0);
            alu_rem  = (alu_lat_fixed > 0) ? alu_lat_fixed : int'($urandom_range(1, 6));
            res_pend = alu_math(bus.alu_op, bus.alu_a, bus.alu_b);
         end else if (alu_pend && !alu_stall) begin
            alu_rem--;
            if (alu_rem <= 0) begin
               bus.alu_done   = 1'b1;
               bus.alu_result = res_pend;
               alu_pend       = 1'b0;
               n_dones++;
               hold_rem = rand_hold ? int'($urandom_range(0, 3)) : 0;
            end
         end
      end
   end

   initial begin
      bus.rsp_ready = 1'b1;
      forever begin
         @(negedge clk);
         bus.rsp_ready = rdy_low ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   // Scoreboard: records accepted commands, checks responses in order and holds.
   initial begin
      tb_cmd_t     c;
      bit          prev_hold;
      logic [15:0] prev_result;
      logic [2:0]  prev_op;
      logic        prev_err;
      logic        exp_err;
      logic [15:0] exp_res;
      prev_hold   = 1'b0;
      prev_result = '0;
      prev_op     = '0;
      prev_err    = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            prev_hold = 1'b0;
         end else begin
            if (bus.cmd_valid && bus.cmd_ready) begin
               expq.push_back('{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b});
               n_pushes++;
            end
            if (prev_hold) begin
               check_output("rsp_hold_valid", bus.rsp_valid, 1);
               check_output("rsp_hold_result", bus.rsp_result, prev_result);
               check_output("rsp_hold_op", bus.rsp_op, prev_op);
               check_output("rsp_hold_err", bus.rsp_err, prev_err);
            end
            prev_hold   = bus.rsp_valid && !bus.rsp_ready;
            prev_result = bus.rsp_result;
            prev_op     = bus.rsp_op;
            prev_err    = bus.rsp_err;
            if (bus.rsp_valid && bus.rsp_ready) begin
               n_rsps++;
               last_result = bus.rsp_result;
               last_op     = bus.rsp_op;
               last_err    = bus.rsp_err;
               n_tests++;
               assert (expq.size() > 0) else begin
                  n_fail++;
                  $error("[TB] FAIL unexpected_rsp: observed op %0d result 0x%0h, expected no response",
                         bus.rsp_op, bus.rsp_result);
               end
               if (expq.size() > 0) begin
                  c       = expq.pop_front();
                  exp_err = (c.op == OP_NONE) || (c.op == OP_DIV && c.b == 8'd0);
                  exp_res = exp_err ? 16'h0000 : alu_math(c.op, c.a, c.b);
                  check_output("rsp_op", bus.rsp_op, c.op);
                  check_output("rsp_err", bus.rsp_err, exp_err);
                  check_output("rsp_result", bus.rsp_result, exp_res);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic drive_cmd(input logic valid, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      bus.cmd_valid = valid;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
   endtask

   task automatic apply_stimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int budget;
      budget = 200;
      @(negedge clk);
      drive_cmd(1'b1, op, a, b);
      #3;
      while (!bus.cmd_ready && budget > 0) begin
         @(negedge clk);
         #3;
         budget--;
      end
      check_output("cmd_accept", bus.cmd_ready, 1);
      @(negedge clk);
      drive_cmd(1'b0, 3'd0, 8'd0, 8'd0);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #3;
         n++;
      end while ((busy || expq.size() != 0) && n < budget);
      check_output("idle_reached", {30'b0, busy, expq.size() == 0}, 32'd1);
   endtask

   task automatic check_reset_values();
      check_output("rst_rsp_valid", bus.rsp_valid, 0);
      check_output("rst_rsp_result", bus.rsp_result, 0);
      check_output("rst_rsp_op", bus.rsp_op, 0);
      check_output("rst_rsp_err", bus.rsp_err, 0);
      check_output("rst_alu_start", bus.alu_start, 0);
      check_output("rst_alu_op", bus.alu_op, 0);
      check_output("rst_alu_a", bus.alu_a, 0);
      check_output("rst_alu_b", bus.alu_b, 0);
      check_output("rst_cmd_ready", bus.cmd_ready, 1);
      check_output("rst_busy", busy, 0);
      check_output("rst_fifo_level", fifo_level, 0);
   endtask

   initial begin
      int s0;
      int r0;
      int p0;
      int d0;
      int n;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;

      drive_cmd(1'b0, 3'd0, 8'd0, 8'd0);
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      check_reset_values();
      @(negedge clk);
      reset = 1'b0;

      // ADD with a one-cycle ALU
      s0 = n_starts;
      r0 = n_rsps;
      alu_lat_fixed = 1;
      apply_stimulus(OP_ADD, 8'd100, 8'd27);
      wait_idle(50);
      check_output("add_starts", n_starts - s0, 1);
      check_output("add_rsps", n_rsps - r0, 1);
      check_output("add_result", last_result, 16'd127);
      check_output("add_op", last_op, OP_ADD);
      check_output("add_err", last_err, 0);

      // MUL with a slow ALU and a stalled response port
      alu_lat_fixed = 9;
      rdy_low = 1'b1;
      apply_stimulus(OP_MUL, 8'hF4, 8'd11);
      n = 0;
      while (!bus.rsp_valid && n < 40) begin
         check_output("mul_busy_wait", busy, 1);
         @(negedge clk);
         #3;
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check_output("mul_rsp_valid", bus.rsp_valid, 1);
         check_output("mul_rsp_result", bus.rsp_result, 16'hFF7C);
         check_output("mul_busy", busy, 1);
         @(negedge clk);
         #3;
      end
      rdy_low = 1'b0;
      wait_idle(50);
      check_output("mul_last_result", last_result, 16'hFF7C);

      // Fill the FIFO while the ALU is stalled
      alu_stall = 1'b1;
      alu_lat_fixed = 2;
      p0 = n_pushes;
      r0 = n_rsps;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         op = 3'($urandom_range(0, 6));
         b  = 8'($urandom);
         if (op == OP_DIV && b == 8'd0) b = 8'd3;
         drive_cmd(1'b1, op, 8'($urandom), b);
      end
      #3;
      check_output("fill_level", fifo_level, 4);
      check_output("fill_cmd_ready", bus.cmd_ready, 0);
      check_output("fill_pushes", n_pushes - p0, 5);
      @(negedge clk);
      drive_cmd(1'b0, 3'd0, 8'd0, 8'd0);
      alu_stall = 1'b0;
      alu_lat_fixed = 0;
      wait_idle(300);
      check_output("fill_rsps", n_rsps - r0, 5);

      // Invalid opcode completes without touching the ALU
      s0 = n_starts;
      apply_stimulus(OP_NONE, 8'h5A, 8'hA5);
      #3;
      n = 0;
      while (!bus.rsp_valid && n < 5) begin
         @(negedge clk);
         #3;
         n++;
      end
      check_output("op7_latency_ok", n <= 2, 1);
      check_output("op7_err", bus.rsp_err, 1);
      check_output("op7_result", bus.rsp_result, 0);
      check_output("op7_op", bus.rsp_op, OP_NONE);
      wait_idle(20);
      check_output("op7_starts", n_starts - s0, 0);

      // Hung divide times out, the queued ADD follows normally
      alu_lat_fixed = 1;
      s0 = n_starts;
      @(negedge clk);
      drive_cmd(1'b1, OP_DIV, 8'd50, 8'd0);
      @(negedge clk);
      drive_cmd(1'b1, OP_ADD, 8'd5, 8'd6);
      @(negedge clk);
      drive_cmd(1'b0, 3'd0, 8'd0, 8'd0);
      #3;
      check_output("div_start", bus.alu_start, 1);
      n = 0;
      while (!bus.rsp_valid && n < 200) begin
         @(negedge clk);
         #3;
         n++;
      end
      check_output("timeout_cycles", n, TIMEOUT + 1);
      check_output("timeout_err", bus.rsp_err, 1);
      check_output("timeout_result", bus.rsp_result, 0);
      check_output("timeout_op", bus.rsp_op, OP_DIV);
      wait_idle(50);
      check_output("timeout_starts", n_starts - s0, 2);
      check_output("after_timeout_result", last_result, 16'd11);

      // Reset during WAIT with two commands queued
      alu_stall = 1'b1;
      alu_lat_fixed = 2;
      @(negedge clk);
      drive_cmd(1'b1, OP_SUB, 8'd9, 8'd4);
      @(negedge clk);
      drive_cmd(1'b1, OP_XOR, 8'hF0, 8'h0F);
      @(negedge clk);
      drive_cmd(1'b1, OP_OR, 8'h11, 8'h22);
      @(negedge clk);
      drive_cmd(1'b0, 3'd0, 8'd0, 8'd0);
      #3;
      check_output("prereset_level", fifo_level, 2);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_values();
      expq.delete();
      @(negedge clk);
      reset = 1'b0;
      alu_stall = 1'b0;
      r0 = n_rsps;
      s0 = n_starts;
      d0 = n_dones;
      repeat (12) @(negedge clk);
      #3;
      check_output("late_done_seen", n_dones > d0, 1);
      check_output("late_done_rsps", n_rsps - r0, 0);
      check_output("late_done_starts", n_starts - s0, 0);
      check_output("late_done_busy", busy, 0);

      // Randomized stream with random latency, done hold and back-pressure
      alu_lat_fixed = 0;
      rand_hold = 1'b1;
      rdy_rand = 1'b1;
      r0 = n_rsps;
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = 8'($urandom);
         b  = 8'($urandom);
         if (op == OP_DIV && b == 8'd0) b = 8'd1;
         apply_stimulus(op, a, b);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle(2000);
      check_output("random_rsps", n_rsps - r0, 40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU start/op/operand -> result/done handshake.
- Buffers operation commands from an upstream requester in a small FIFO and issues them one at a time to the ALU core.
- Waits for ALU completion, then returns the captured result on a valid/ready response port.
- Invalid opcodes and hung operations complete locally with an error flag.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- TIMEOUT, 64, max cycles in WAIT before the operation is declared hung (>=8)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  upstream command present
- cmd_ready  out  1  FIFO can accept a command (= !full)
- cmd_op  in  3  opcode
- cmd_a  in  8  signed operand A
- cmd_b  in  8  signed operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  downstream accepts response
- rsp_op  out  3  opcode of completed command
- rsp_result  out  16  signed result (0 when rsp_err)
- rsp_err  out  1  1 = invalid opcode or timeout
- alu_start  out  1  one-cycle start pulse to ALU
- alu_op  out  3  opcode to ALU, stable from ISSUE until leaving WAIT
- alu_a  out  8  operand A to ALU, same stability as alu_op
- alu_b  out  8  operand B to ALU, same stability as alu_op
- alu_result  in  16  ALU result
- alu_done  in  1  ALU completion
- busy  out  1  FSM not IDLE or FIFO non-empty
- fifo_level  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (async, any state):
  - FSM -> IDLE; FIFO emptied; timeout counter = 0.
  - Outputs: rsp_valid=0, rsp_result=0, rsp_op=0, rsp_err=0, alu_start=0, alu_op/alu_a/alu_b=0, cmd_ready=1, busy=0, fifo_level=0.
  - An in-flight ALU operation is abandoned; a later alu_done is ignored (see DRAIN).
- FIFO:
  - Push on cmd_valid & cmd_ready.
  - Pop only when the FSM leaves IDLE.
  - cmd_ready = !full. No same-cycle pass-through when full: a push at full is refused even if a pop occurs that cycle.
  - Push and pop in the same cycle when not full: level unchanged.
  - Pointers carry an extra wrap bit; full/empty are decided on the wrap bit.
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
  - IDLE, FIFO non-empty, head op = 3'b111: pop; rsp_err=1, rsp_result=0, rsp_op=7; -> RESP. The ALU is not touched.
  - IDLE, FIFO non-empty, head op 0..6: pop; latch op/a/b onto alu_*; -> ISSUE.
  - ISSUE: alu_start=1 for exactly this cycle; counter cleared; -> WAIT.
  - WAIT, alu_done=1: capture alu_result and rsp_op; rsp_err=0; -> RESP.
  - WAIT, counter reaches TIMEOUT-1 with no alu_done: rsp_err=1, rsp_result=0; -> RESP. Otherwise the counter increments each cycle.
  - RESP: rsp_valid=1; rsp_* held stable until rsp_ready. On acceptance: -> IDLE if alu_done=0, else -> DRAIN.
  - DRAIN: wait for alu_done=0, then -> IDLE. Guarantees a held-high done is never reused for the next command.
- Latency:
  - Command accepted at edge k; earliest pop at edge k+1; alu_start high in cycle k+1..k+2.
  - Response valid the cycle after alu_done is sampled.
  - Back-to-back throughput: one command per (ALU latency + 3) cycles with rsp_ready=1.
- Width rules: operands pass through unmodified (signed 8-bit); the result is captured as 16 bits. No arithmetic is performed in this block.
- Only one ALU operation is ever outstanding; alu_start is never asserted outside ISSUE.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_AND=4, OP_OR=5, OP_XOR=6, OP_NONE=7
  - FSM state encoding
  - command record width (3+8+8=19)
- Sub-module alu_cmd_fifo:
  - parameters DEPTH and WIDTH=19
  - push/pop/full/empty/level
  - async active-high reset
- The FSM, timeout counter and response register stay in alu_cmd_issuer.

Test Plan:
- Single ADD, a=8'sd100, b=8'sd27, model ALU done 1 cycle after start with result 127 -> exactly one alu_start pulse; rsp_valid with rsp_result=16'sd127, rsp_op=0, rsp_err=0.
- MUL, a=-8'sd12, b=8'sd11, done after 9 cycles, rsp_ready held low 5 cycles -> rsp_result=16'hFF7C (-132) held stable until accept; busy=1 throughout.
- Fill with cmd_valid held high, ALU stalled (done=0) -> 4 pushes accepted plus 1 popped into ISSUE; cmd_ready=0 at fifo_level=4; push attempted at full is refused; responses return in FIFO order.
- op=7 command -> no alu_start; rsp_err=1, rsp_result=0, rsp_op=7 within 2 cycles.
- DIV with alu_done never asserted, TIMEOUT=64 -> rsp_err=1 at cycle 64 of WAIT; next queued command then issues normally.
- Reset asserted mid-WAIT with 2 entries queued -> all outputs at reset values immediately; fifo_level=0; a late alu_done pulse after reset produces no response.
